// File: rtl/data_mem_io.sv
// Data-side memory stage: word-organised data RAM with byte/half/word
// loads and stores, a small memory-mapped I/O window (GPIO out, cycle
// counter, synchronised GPIO in), and the MemtoReg write-back select.
module data_mem_io #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] IO_BASE     = 32'h8000_0000,
    parameter int unsigned GPIO_W      = 8
) (
    input  logic              CLOCK,
    input  logic              RST,
    input  logic [31:0]       alu_out_ext,
    input  logic [31:0]       dataram_wr,
    input  logic              ena_wr,
    input  logic              ena_rd,
    input  logic              MemtoReg_sig,
    input  logic [2:0]        funct3,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [31:0]       datareg_wr,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              mem_err
);

    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [31:0] A_GPO     = IO_BASE;
    localparam logic [31:0] A_CYC     = IO_BASE + 32'd4;
    localparam logic [31:0] A_GPI     = IO_BASE + 32'd8;

    logic [31:0]       mem_q [DEPTH_WORDS];
    logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
    logic [31:0]       cyc_q, cyc_d;
    logic [GPIO_W-1:0] gpi_s1_q, gpi_s2_q;
    logic              mem_err_q, mem_err_d;

    logic [1:0]    size;
    logic          access;
    logic          ram_hit, hit_gpo, hit_cyc, hit_gpi, io_hit;
    logic          size_bad, misaligned, unmapped, io_not_word, ro_write;
    logic          acc_err, store_ok, ram_we;
    logic [AW-1:0] word_idx;
    logic [3:0]    lane_en;
    logic [31:0]   lane_data;
    logic [31:0]   src_word, byte_shift, half_shift, load_data;

    assign size     = funct3[1:0];
    assign access   = ena_wr | ena_rd;
    assign word_idx = alu_out_ext[AW+1:2];

    // Address decode and access-error classification.
    always_comb begin
        ram_hit     = {1'b0, alu_out_ext} < RAM_BYTES;
        hit_gpo     = alu_out_ext == A_GPO;
        hit_cyc     = alu_out_ext == A_CYC;
        hit_gpi     = alu_out_ext == A_GPI;
        io_hit      = hit_gpo | hit_cyc | hit_gpi;
        size_bad    = (size == 2'b11) || (ena_rd && funct3 == 3'b110);
        misaligned  = ((size == 2'b01) && alu_out_ext[0]) ||
                      ((size == 2'b10) && (alu_out_ext[1:0] != 2'b00));
        unmapped    = !ram_hit && !io_hit;
        io_not_word = io_hit && (size != 2'b10);
        ro_write    = ena_wr && hit_gpi;
        acc_err     = access && (size_bad || misaligned || unmapped || io_not_word || ro_write);
        store_ok    = ena_wr && !acc_err && !RST;
        ram_we      = store_ok && ram_hit;
    end

    // Store lane enables and lane-replicated store data.
    always_comb begin
        lane_en   = '0;
        lane_data = dataram_wr;
        unique case (size)
            2'b00: begin
                lane_en   = 4'b0001 << alu_out_ext[1:0];
                lane_data = {4{dataram_wr[7:0]}};
            end
            2'b01: begin
                lane_en   = alu_out_ext[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{dataram_wr[15:0]}};
            end
            2'b10: lane_en = '1;
            default: lane_en = '0;
        endcase
    end

    // RAM byte-lane write; contents are intentionally not reset.
    always_ff @(posedge CLOCK) begin
        if (ram_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem_q[word_idx][i*8 +: 8] <= lane_data[i*8 +: 8];
                end
            end
        end
    end

    // Next-state for I/O registers and the sticky error flag.
    always_comb begin
        gpio_out_d = gpio_out_q;
        cyc_d      = cyc_q + 32'd1;
        mem_err_d  = mem_err_q | acc_err;
        if (store_ok && hit_gpo) gpio_out_d = dataram_wr[GPIO_W-1:0];
        if (store_ok && hit_cyc) cyc_d = dataram_wr;
    end

    // I/O register state and two-flop input synchroniser.
    always_ff @(posedge CLOCK) begin
        if (RST) begin
            gpio_out_q <= '0;
            cyc_q      <= '0;
            gpi_s1_q   <= '0;
            gpi_s2_q   <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            gpio_out_q <= gpio_out_d;
            cyc_q      <= cyc_d;
            gpi_s1_q   <= gpio_in;
            gpi_s2_q   <= gpi_s1_q;
            mem_err_q  <= mem_err_d;
        end
    end

    // Combinational load path: source select, lane align, extend.
    always_comb begin
        if (ram_hit)      src_word = mem_q[word_idx];
        else if (hit_gpo) src_word = 32'(gpio_out_q);
        else if (hit_cyc) src_word = cyc_q;
        else if (hit_gpi) src_word = 32'(gpi_s2_q);
        else              src_word = '0;
        byte_shift = src_word >> {alu_out_ext[1:0], 3'b000};
        half_shift = src_word >> {alu_out_ext[1], 4'b0000};
        unique case (size)
            2'b00:   load_data = funct3[2] ? {24'd0, byte_shift[7:0]}
                                           : {{24{byte_shift[7]}}, byte_shift[7:0]};
            2'b01:   load_data = funct3[2] ? {16'd0, half_shift[15:0]}
                                           : {{16{half_shift[15]}}, half_shift[15:0]};
            2'b10:   load_data = src_word;
            default: load_data = '0;
        endcase
        if (!ena_rd || acc_err) load_data = '0;
    end

    assign datareg_wr = MemtoReg_sig ? load_data : alu_out_ext;
    assign gpio_out   = gpio_out_q;
    assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_data_mem_io.sv
// Randomised and directed bench for data_mem_io against a byte-level
// behavioural model of the memory map.
module tb_data_mem_io;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] IOB   = 32'h8000_0000;
    localparam logic [31:0] A_GPO = IOB;
    localparam logic [31:0] A_CYC = IOB + 32'd4;
    localparam logic [31:0] A_GPI = IOB + 32'd8;

    logic        CLOCK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] alu_out_ext = '0;
    logic [31:0] dataram_wr = '0;
    logic        ena_wr = 1'b0;
    logic        ena_rd = 1'b0;
    logic        MemtoReg_sig = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [7:0]  gpio_in = '0;
    logic [31:0] datareg_wr;
    logic [7:0]  gpio_out;
    logic        mem_err;

    data_mem_io #(.DEPTH_WORDS(DEPTH), .IO_BASE(IOB), .GPIO_W(8)) dut (
        .CLOCK(CLOCK), .RST(RST), .alu_out_ext(alu_out_ext), .dataram_wr(dataram_wr),
        .ena_wr(ena_wr), .ena_rd(ena_rd), .MemtoReg_sig(MemtoReg_sig), .funct3(funct3),
        .gpio_in(gpio_in), .datareg_wr(datareg_wr), .gpio_out(gpio_out), .mem_err(mem_err)
    );

    always #5 CLOCK = ~CLOCK;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    // reference state
    bit [7:0]   ref_mem [DEPTH*4];
    bit [7:0]   ref_gpo = '0;
    bit [31:0]  ref_cyc = '0;
    bit         ref_err = 1'b0;
    bit [7:0]   gin_hist [$] = '{8'h00, 8'h00};
    logic [31:0] last_wb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    endtask

    // Spec-level evaluation of one access: error flag and returned load data.
    function automatic void model_eval(input logic [31:0] addr, input logic [2:0] f3,
                                       input bit wr, input bit rd,
                                       output bit err, output logic [31:0] ld);
        int unsigned nb;
        bit illegal, mis, is_ram, is_io;
        nb      = 1 << f3[1:0];
        illegal = (f3[1:0] == 2'b11) || (rd && f3 == 3'b110);
        mis     = !illegal && ((addr % nb) != 0);
        is_ram  = longint'(addr) < longint'(DEPTH * 4);
        is_io   = (addr == A_GPO) || (addr == A_CYC) || (addr == A_GPI);
        err = (wr || rd) && (illegal || mis || (!is_ram && !is_io) ||
                             (is_io && f3[1:0] != 2'b10) || (wr && addr == A_GPI));
        ld = '0;
        if (!rd || err) return;
        if (is_ram) begin
            for (int k = 0; k < int'(nb); k++) ld[k*8 +: 8] = ref_mem[addr + k];
            if (!f3[2] && nb == 1 && ld[7])  ld[31:8]  = '1;
            if (!f3[2] && nb == 2 && ld[15]) ld[31:16] = '1;
        end else if (addr == A_GPO) ld = {24'd0, ref_gpo};
        else if (addr == A_CYC)     ld = ref_cyc;
        else                        ld = {24'd0, gin_hist[$-1]};
    endfunction

    // Spec-level state change at a rising edge.
    function automatic void model_update(input bit rst, input logic [31:0] addr,
                                         input logic [31:0] wd, input bit wr, input bit err,
                                         input logic [2:0] f3, input logic [7:0] gin);
        int unsigned nb;
        nb = 1 << f3[1:0];
        if (rst) begin
            ref_gpo = '0; ref_cyc = '0; ref_err = 1'b0;
            gin_hist = '{8'h00, 8'h00};
            return;
        end
        if (wr && !err && longint'(addr) < longint'(DEPTH * 4))
            for (int k = 0; k < int'(nb); k++) ref_mem[addr + k] = wd[k*8 +: 8];
        if (wr && !err && addr == A_GPO) ref_gpo = wd[7:0];
        if (wr && !err && addr == A_CYC) ref_cyc = wd;
        else                             ref_cyc = ref_cyc + 32'd1;
        ref_err = ref_err | err;
        gin_hist.push_back(gin);
    endfunction

    task automatic do_cycle(input bit rst, input logic [31:0] addr, input logic [31:0] wd,
                            input bit wr, input bit rd, input logic [2:0] f3, input bit m2r);
        bit e;
        logic [31:0] ld;
        @(negedge CLOCK);
        RST = rst; alu_out_ext = addr; dataram_wr = wd;
        ena_wr = wr; ena_rd = rd; funct3 = f3; MemtoReg_sig = m2r;
        #1;
        model_eval(addr, f3, wr, rd, e, ld);
        last_wb = datareg_wr;
        check("wb", datareg_wr, m2r ? ld : addr);
        @(posedge CLOCK);
        model_update(rst, addr, wd, wr, e, f3, gpio_in);
        #1;
        check("gpio_out", {24'd0, gpio_out}, {24'd0, ref_gpo});
        check("mem_err", {31'd0, mem_err}, {31'd0, ref_err});
    endtask

    task automatic rd_op(input logic [31:0] addr, input logic [2:0] f3);
        do_cycle(1'b0, addr, 32'd0, 1'b0, 1'b1, f3, 1'b1);
    endtask

    task automatic wr_op(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3);
        do_cycle(1'b0, addr, wd, 1'b1, 1'b0, f3, 1'b0);
    endtask

    task automatic reset_op();
        do_cycle(1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 3'b010, 1'b0);
    endtask

    initial begin
        reset_op();
        reset_op();
        check("rst_gpio", {24'd0, gpio_out}, 32'd0);
        check("rst_err", {31'd0, mem_err}, 32'd0);

        // counter after reset
        for (int i = 0; i < 5; i++) do_cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 3'b010, 1'b0);
        rd_op(A_CYC, 3'b010);   check("cyc5", last_wb, 32'd5);

        // word store and sized loads
        wr_op(32'h10, 32'hDEADBEEF, 3'b010);
        rd_op(32'h10, 3'b010);  check("lw10", last_wb, 32'hDEADBEEF);
        rd_op(32'h13, 3'b000);  check("lb13", last_wb, 32'hFFFFFFDE);
        rd_op(32'h13, 3'b100);  check("lbu13", last_wb, 32'h000000DE);
        rd_op(32'h12, 3'b001);  check("lh12", last_wb, 32'hFFFFDEAD);
        rd_op(32'h10, 3'b101);  check("lhu10", last_wb, 32'h0000BEEF);
        wr_op(32'h11, 32'h55, 3'b000);
        rd_op(32'h10, 3'b010);  check("sb_merge", last_wb, 32'hDEAD55EF);
        do_cycle(1'b0, 32'h10, 32'h1, 1'b1, 1'b1, 3'b010, 1'b1);
        check("rw_old", last_wb, 32'hDEAD55EF);
        rd_op(32'h10, 3'b010);  check("rw_new", last_wb, 32'h00000001);

        // error cases, each from a clean reset
        check("err_pre", {31'd0, mem_err}, 32'd0);
        rd_op(32'h12, 3'b010);  check("lw_mis", last_wb, 32'd0);
        check("err_lw_mis", {31'd0, mem_err}, 32'd1);
        reset_op();
        wr_op(32'h11, 32'hFFFF, 3'b001);
        check("err_sh_mis", {31'd0, mem_err}, 32'd1);
        rd_op(32'h10, 3'b010);  check("sh_mis_nowr", last_wb, 32'h00000001);
        check("err_sticky", {31'd0, mem_err}, 32'd1);
        reset_op();
        rd_op(32'h10, 3'b011);  check("ld_f3_011", last_wb, 32'd0);
        check("err_f3", {31'd0, mem_err}, 32'd1);
        reset_op();
        rd_op(DEPTH * 4, 3'b010); check("lw_oob", last_wb, 32'd0);
        check("err_oob", {31'd0, mem_err}, 32'd1);
        reset_op();
        check("err_clr", {31'd0, mem_err}, 32'd0);

        // counter wrap
        wr_op(A_CYC, 32'hFFFF_FFFE, 3'b010);
        rd_op(A_CYC, 3'b010);   check("cyc_fe", last_wb, 32'hFFFF_FFFE);
        rd_op(A_CYC, 3'b010);   check("cyc_ff", last_wb, 32'hFFFF_FFFF);
        rd_op(A_CYC, 3'b010);   check("cyc_wrap", last_wb, 32'h0000_0000);

        // GPIO
        wr_op(A_GPO, 32'h1A5, 3'b010);
        check("gpo_a5", {24'd0, gpio_out}, 32'h000000A5);
        rd_op(A_GPO, 3'b010);   check("gpo_rd", last_wb, 32'h000000A5);
        wr_op(A_GPO, 32'h11, 3'b000);
        check("gpo_sb_ign", {24'd0, gpio_out}, 32'h000000A5);
        check("gpo_sb_err", {31'd0, mem_err}, 32'd1);
        gpio_in = 8'h3C;
        rd_op(A_GPI, 3'b010);   check("gpi_e0", last_wb, 32'h00);
        rd_op(A_GPI, 3'b010);   check("gpi_e1", last_wb, 32'h00);
        rd_op(A_GPI, 3'b010);   check("gpi_e2", last_wb, 32'h3C);

        // reset during a store
        do_cycle(1'b1, 32'h10, 32'hCAFEF00D, 1'b1, 1'b0, 3'b010, 1'b0);
        check("rst_gpo", {24'd0, gpio_out}, 32'd0);
        check("rst_err2", {31'd0, mem_err}, 32'd0);
        rd_op(A_CYC, 3'b010);   check("rst_cyc", last_wb, 32'd0);
        rd_op(32'h10, 3'b010);  check("rst_nowr", last_wb, 32'h00000001);

        // MemtoReg bypass
        do_cycle(1'b0, 32'h1234, 32'd0, 1'b0, 1'b1, 3'b010, 1'b0);
        check("m2r0", last_wb, 32'h1234);

        // randomised traffic over a pre-initialised RAM window and the I/O map
        for (int w = 0; w < 16; w++) wr_op(32'h100 + 32'(w * 4), $urandom, 3'b010);
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int unsigned sel;
            sel = $urandom_range(0, 9);
            if (sel <= 5)      a = 32'h100 + 32'($urandom_range(0, 63));
            else if (sel == 6) a = IOB + 32'(4 * $urandom_range(0, 2));
            else if (sel == 7) a = IOB + 32'($urandom_range(0, 15));
            else if (sel == 8) a = DEPTH * 4 + 32'($urandom_range(0, 8));
            else               a = $urandom | 32'h4000_0000;
            if ($urandom_range(0, 7) == 0) gpio_in = 8'($urandom);
            do_cycle($urandom_range(0, 39) == 0, a, $urandom, 1'($urandom), 1'($urandom),
                     3'($urandom_range(0, 7)), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_io.md
Name: data_mem_io

Overview:
Data-side memory stage fed directly by the single-cycle core's ALU/store outputs (address, store data, read/write enables, MemtoReg select). It holds the word-organised data RAM with byte/half/word loads and stores, plus a small memory-mapped I/O window: GPIO output register, free-running cycle counter and synchronised GPIO input. It returns the register-file write-back value, so it also performs the MemtoReg selection.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit RAM words; RAM occupies byte addresses 0 .. DEPTH_WORDS*4-1
IO_BASE, 32'h8000_0000, base byte address of the I/O window
GPIO_W, 8, width of gpio_out and gpio_in (1..32)

Ports:
CLOCK  in  1  single clock; all state updates on the rising edge
RST  in  1  synchronous reset, active-high
alu_out_ext  in  32  byte address; also the non-memory write-back value
dataram_wr  in  32  store data (rs2)
ena_wr  in  1  store enable
ena_rd  in  1  load enable
MemtoReg_sig  in  1  1 = write back load data, 0 = write back alu_out_ext
funct3  in  3  instr[14:12], the access size and sign
gpio_in  in  GPIO_W  asynchronous external inputs
datareg_wr  out  32  write-back data to the register file
gpio_out  out  GPIO_W  GPIO output register
mem_err  out  1  sticky error flag

Behaviour:
- Reset (RST=1 at a rising edge):
  - gpio_out, the cycle counter, both gpio_in synchroniser stages and mem_err are cleared to 0.
  - Any store presented in that cycle is suppressed.
  - RAM contents are not reset.
- Decode:
  - RAM hit when alu_out_ext < DEPTH_WORDS*4; word index = alu_out_ext[31:2].
  - IO_BASE+0: GPIO_OUT, read/write.
  - IO_BASE+4: CYCLE, read/write.
  - IO_BASE+8: GPIO_IN, read-only.
  - Any other address is unmapped.
- Size is funct3[1:0]: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]≠0.
- Error condition, when ena_wr or ena_rd is high: illegal size, misaligned, unmapped, a non-word access to an I/O register, or a write to GPIO_IN.
  - On error: the store is suppressed, load data = 0, and mem_err is set at the next edge.
  - mem_err stays set until reset.
- RAM store (ena_wr=1, no error): written at the rising edge using lane enables.
  - SB writes lane addr[1:0] with dataram_wr[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with dataram_wr[15:0].
  - SW writes all four lanes.
  - Unselected lanes are unchanged.
- Load (ena_rd=1) is combinational, zero-cycle latency, from the pre-edge contents.
  - The selected lane is right-aligned.
  - funct3 000 = LB sign-extended; 001 = LH sign-extended; 010 = LW; 100 = LBU zero-extended; 101 = LHU zero-extended.
  - funct3 110/111 are illegal.
  - Load data = 0 when ena_rd=0.
- Simultaneous ena_wr and ena_rd to the same address: the load returns the old value; the new value is visible from the next cycle.
- GPIO_OUT:
  - SW writes dataram_wr[GPIO_W-1:0] at the edge.
  - A read returns the register zero-extended.
- CYCLE:
  - 32-bit counter, increments by 1 every cycle when not in reset.
  - Wraps from 0xFFFF_FFFF to 0.
  - On SW, the counter loads dataram_wr, and the load has priority over the increment that cycle.
  - A read returns the current (pre-edge) value.
- GPIO_IN:
  - Two-flop synchroniser, so a change on gpio_in is readable 2 edges later.
  - A read returns the synchronised value zero-extended.
- datareg_wr = MemtoReg_sig ? load data : alu_out_ext.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 → 0xDEADBEEF. LB @0x13 → 0xFFFFFFDE. LBU @0x13 → 0x000000DE. LH @0x12 → 0xFFFFDEAD. LHU @0x10 → 0x0000BEEF.
- After the previous test, SB 0x55 @0x11, then LW @0x10 → 0xDEAD55EF. Same-cycle SW 0x1 and LW @0x10 → old value 0xDEAD55EF, then 0x00000001 on the next cycle.
- LW @0x12, SH @0x11, funct3=011 with ena_rd, and LW @DEPTH_WORDS*4 → each returns 0 with no RAM change. mem_err rises at the next edge and stays high until RST.
- Counter:
  - After RST, LW CYCLE 5 cycles later → 5.
  - SW 0xFFFF_FFFE to CYCLE, then read on the following cycles → 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- GPIO:
  - SW 0x1A5 to GPIO_OUT → gpio_out = 0xA5 (GPIO_W=8).
  - SB to GPIO_OUT → ignored, mem_err set.
  - gpio_in goes 0x00→0x3C → LW GPIO_IN returns 0x00 for 2 edges, then 0x3C.
- Reset mid-operation and MemtoReg:
  - Assert RST during a SW → no RAM write; gpio_out, counter and mem_err are 0.
  - With MemtoReg_sig=0 and alu_out_ext=0x1234 → datareg_wr = 0x1234 regardless of the load data.
